perips_timer_sched: RTL
=======================

# perips_timer_sched

Round-robin scheduler that shares the single peripheral timer between `NUM_REQ` hardware requesters, each needing a one-shot delay. It sits between the requesters and the timer's register port. It acts as the timer's only bus master, and for each granted request it:

- programs the timer (CR, PSC, LOAD, CR),
- waits for the timer interrupt pulse,
- stops the timer and returns a one-cycle done pulse to the owner.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DW`, `` `DATA_BUS_WIDTH `` (32): register data width.
- `clk_i` input 1: single clock, all logic on rising edge.
- `rst_n_i` input 1: reset, asynchronous and active-low.
- `req_i` input NUM_REQ: per-requester delay request, level; held until `done_o` bit or withdrawn (abort).
- `req_psc_i` input NUM_REQ*DW: slice k = prescale for requester k (timer tick = PSC+1 clocks).
- `req_load_i` input NUM_REQ*DW: slice k = tick count for requester k.
- `done_o` output NUM_REQ: one-cycle pulse to the owner when its delay expires.
- `busy_o` output 1: high from grant until return to IDLE.
- `cur_id_o` output $clog2(NUM_REQ): index of current owner; valid while `busy_o`.
- `tmr_addr_o` output 8: timer register address.
- `tmr_we_o` output 1: timer write strobe, one cycle per write.
- `tmr_rd_o` output 1: timer read strobe, constant 0.
- `tmr_data_o` output DW: timer write data.
- `tmr_irq_i` input 1: timer interrupt. This is a one-cycle pulse, because the SR flag self-clears.

Timer map: CR 0x00 (bit0 enable), SR 0x04, PSC 0x08, LOAD 0x0C, COUNT 0x10.

## Operation
- States: IDLE, ARB, WR_CR0, WR_PSC, WR_LOAD, WR_CR1, WAIT, STOP, DONE.
- **IDLE:** if any `req_i` bit is set, go to ARB.
- **ARB:**
  - Select the first set `req_i` bit searching upward from `rr_ptr` (wrapping); this becomes `id`.
  - Latch `req_psc_i[id]` and `req_load_i[id]` into internal registers.
  - Set `busy_o`.
  - If no bit is set in ARB (request withdrawn), return to IDLE.
- **WR_CR0:** write CR=0, so the timer is stopped and COUNT reloads.
- **WR_PSC:** write PSC = latched psc.
- **WR_LOAD:** write LOAD = latched load.
- **WR_CR1:** write CR=1.
- **WAIT:**
  - If `tmr_irq_i`=1, go to STOP with completion flag set.
  - Else if `req_i[id]`=0, go to STOP with the flag clear (abort).
  - `tmr_irq_i` has priority over a simultaneous withdrawal: that case completes.
- **STOP:** write CR=0.
- **DONE:**
  - If the completion flag is set, pulse `done_o[id]` for this cycle.
  - Set `rr_ptr` = (id+1) mod NUM_REQ, on both completion and abort.
  - Clear `busy_o`; go to IDLE.
- `tmr_irq_i` outside WAIT is ignored.
- Changes to `req_psc_i`/`req_load_i` after ARB have no effect on the current delay.
- LOAD=0 is legal: the timer fires almost immediately and the sequence completes normally.
- PSC/LOAD are passed unmodified at full DW width; no arithmetic is applied to them.

## Timing
- In each WR_* and STOP state: `tmr_we_o`=1 with addr/data valid for exactly that one cycle. In all other states: `tmr_we_o`=0, `tmr_addr_o`=0, `tmr_data_o`=0.
- Fixed latencies, with the edge at which the state is entered counting as cycle 0:
  - `req_i` rising while IDLE → ARB at cycle 1.
  - First timer write (CR=0) at cycle 2.
  - CR=1 write at cycle 5.
  - WAIT from cycle 6.
- Completion: if the irq is seen in WAIT at cycle t, STOP write occurs at t+1 and the `done_o` pulse at t+2. Back in IDLE at t+3; a new ARB can follow at t+4.
- The timer side fires nominally (LOAD)·(PSC+1)+2 cycles after the CR=1 write. This is a timer property; the scheduler only reacts to `tmr_irq_i`.
- Reset values: all outputs 0, state IDLE, `rr_ptr`=0, latched psc/load = 0.
- Reset asserted mid-operation:
  - Immediately returns to IDLE with all outputs 0.
  - No `done_o` pulse is produced.
  - The timer shares the reset, so it is stopped too.
- At most one `done_o` bit is high in any cycle. `done_o` is never asserted for a requester that aborted.

## Test plan
- **Single request:** req_i=0001, psc=1, load=3.
  - Writes seen in order: CR=0, PSC=1, LOAD=3, CR=1 at cycles 2..5.
  - `done_o`=0001 pulse 2 cycles after the irq pulse.
  - Then IDLE with `busy_o`=0.
- **Round-robin fairness:** req_i=1111 held, all load=2, psc=0. Grants go in order 0,1,2,3,0. Each `done_o` bit pulses once per round.
- **Abort:** requester 2 granted with load=100. Drop req_i[2] in WAIT.
  - STOP write CR=0 next cycle.
  - No `done_o`.
  - `rr_ptr`=3 (next grant goes to 3 if requested).
- **Simultaneous irq and withdrawal:** in WAIT, drive `tmr_irq_i`=1 in the same cycle `req_i[id]` falls → `done_o[id]` still pulses.
- **Reset mid-WAIT:**
  - Pulse `rst_n_i` low during WAIT → all outputs 0 asynchronously, state IDLE.
  - Re-asserted request restarts at requester 0 with a full CR/PSC/LOAD/CR sequence.
- **Edge values:**
  - load=0, psc=0 → completes after the irq with no hang.
  - psc=0xFFFF_FFFF is written unchanged on `tmr_data_o`.
  - Changing `req_load_i` during WAIT leaves the latched value and any later LOAD write unaffected.

Source files
------------

// File: rtl/perips_timer_sched_if.sv
// Timer register-port bus between the scheduler (master) and the timer (slave).
//   tmr_addr_o : register address     tmr_we_o  : one-cycle write strobe
//   tmr_rd_o   : read strobe          tmr_data_o: write data
//   tmr_irq_i  : one-cycle timer interrupt back to the master
interface perips_timer_sched_if #(
   parameter int unsigned DW = 32
);
   logic [7:0]    tmr_addr_o;
   logic          tmr_we_o;
   logic          tmr_rd_o;
   logic [DW-1:0] tmr_data_o;
   logic          tmr_irq_i;

   modport master (
      output tmr_addr_o, tmr_we_o, tmr_rd_o, tmr_data_o,
      input  tmr_irq_i
   );

   modport slave (
      input  tmr_addr_o, tmr_we_o, tmr_rd_o, tmr_data_o,
      output tmr_irq_i
   );
endinterface

// File: rtl/perips_timer_sched.sv
// Round-robin scheduler sharing one peripheral timer between NUM_REQ one-shot
// delay requesters. Per grant: write CR=0, PSC, LOAD, CR=1, wait for the irq
// (or withdrawal), write CR=0, then pulse done_o to the owner on completion.
//   clk_i, rst_n_i : clock, async active-low reset
//   req_i          : per-requester level request
//   req_psc_i      : packed per-requester prescale values
//   req_load_i     : packed per-requester tick counts
//   done_o         : one-cycle completion pulse to the owner
//   busy_o         : high from grant until return to IDLE
//   cur_id_o       : current owner index
//   tmr            : timer register-port master
module perips_timer_sched #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DW      = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [NUM_REQ*DW-1:0]          req_psc_i,
   input  logic [NUM_REQ*DW-1:0]          req_load_i,
   output logic [NUM_REQ-1:0]             done_o,
   output logic                           busy_o,
   output logic [$clog2(NUM_REQ)-1:0]     cur_id_o,
   perips_timer_sched_if.master           tmr
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   localparam logic [7:0] ADDR_CR   = 8'h00;
   localparam logic [7:0] ADDR_PSC  = 8'h08;
   localparam logic [7:0] ADDR_LOAD = 8'h0C;

   typedef enum logic [3:0] {
      IDLE, ARB, WR_CR0, WR_PSC, WR_LOAD, WR_CR1, WAIT, STOP, DONE
   } state_e;

   state_e              state_q;
   logic [IW-1:0]       rr_ptr_q;
   logic [IW-1:0]       id_q;
   logic [DW-1:0]       psc_q;
   logic [DW-1:0]       load_q;
   logic                cmpl_q;
   logic                busy_q;
   logic [NUM_REQ-1:0]  done_q;
   logic                we_q;
   logic [7:0]          addr_q;
   logic [DW-1:0]       data_q;

   logic                grant_found_c;
   logic [IW-1:0]       grant_id_c;
   logic [DW-1:0]       psc_sel_c;
   logic [DW-1:0]       load_sel_c;

   // First set request searching upward from rr_ptr; descending loop so the
   // nearest candidate is assigned last and wins.
   always_comb begin
      grant_found_c = 1'b0;
      grant_id_c    = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         logic [IW-1:0] cand;
         cand = IW'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
         if (req_i[cand]) begin
            grant_found_c = 1'b1;
            grant_id_c    = cand;
         end
      end
   end

   // Payload mux for the candidate being granted.
   always_comb begin
      psc_sel_c  = '0;
      load_sel_c = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (grant_id_c == IW'(k)) begin
            psc_sel_c  = req_psc_i[k*DW +: DW];
            load_sel_c = req_load_i[k*DW +: DW];
         end
      end
   end

   // Sequencer: all bus/handshake outputs are registered alongside the state,
   // so each write is presented during the cycle its WR_*/STOP state is held.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         psc_q    <= '0;
         load_q   <= '0;
         cmpl_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (|req_i) state_q <= ARB;
            end
            ARB: begin
               if (grant_found_c) begin
                  id_q    <= grant_id_c;
                  psc_q   <= psc_sel_c;
                  load_q  <= load_sel_c;
                  busy_q  <= 1'b1;
                  state_q <= WR_CR0;
                  we_q    <= 1'b1;
                  addr_q  <= ADDR_CR;
               end else begin
                  state_q <= IDLE;
               end
            end
            WR_CR0: begin
               state_q <= WR_PSC;
               we_q    <= 1'b1;
               addr_q  <= ADDR_PSC;
               data_q  <= psc_q;
            end
            WR_PSC: begin
               state_q <= WR_LOAD;
               we_q    <= 1'b1;
               addr_q  <= ADDR_LOAD;
               data_q  <= load_q;
            end
            WR_LOAD: begin
               state_q <= WR_CR1;
               we_q    <= 1'b1;
               addr_q  <= ADDR_CR;
               data_q  <= DW'(1);
            end
            WR_CR1: begin
               state_q <= WAIT;
            end
            WAIT: begin
               // irq wins over a same-cycle withdrawal
               if (tmr.tmr_irq_i || !req_i[id_q]) begin
                  cmpl_q  <= tmr.tmr_irq_i;
                  state_q <= STOP;
                  we_q    <= 1'b1;
                  addr_q  <= ADDR_CR;
               end
            end
            STOP: begin
               state_q <= DONE;
               if (cmpl_q) done_q[id_q] <= 1'b1;
            end
            DONE: begin
               rr_ptr_q <= (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + IW'(1);
               busy_q   <= 1'b0;
               cmpl_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign done_o         = done_q;
   assign busy_o         = busy_q;
   assign cur_id_o       = id_q;
   assign tmr.tmr_we_o   = we_q;
   assign tmr.tmr_addr_o = addr_q;
   assign tmr.tmr_data_o = data_q;
   assign tmr.tmr_rd_o   = 1'b0;

endmodule
